// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with a byte-serial refill engine.
// Hits answer combinationally; misses assemble a 32-bit word from four byte reads.
module icache_2way #(
  parameter int ADDR_W  = 17,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rdy_o,
  output logic [31:0]       inst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rdy_i,
  input  logic [7:0]        mem_data_i
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
  state_t state_reg, state_next;

  logic [1:0][SETS-1:0] valid_reg;
  logic [SETS-1:0]      lru_reg;
  logic [TAG_W-1:0]     tag_mem  [2][SETS];
  logic [31:0]          data_mem [2][SETS];

  logic [ADDR_W-1:0]    base_reg;
  logic [1:0]           count_reg;
  logic [31:0]          asm_reg;

  logic [INDEX_W-1:0]   req_index, fill_index;
  logic [TAG_W-1:0]     req_tag, fill_tag;
  logic [1:0]           way_hit;
  logic                 hit;
  logic [31:0]          hit_word;
  logic                 victim;
  logic                 fill_done;
  logic                 unused_addr_lsbs;

  assign req_index        = req_addr_i[INDEX_W+1:2];
  assign req_tag          = req_addr_i[ADDR_W-1:INDEX_W+2];
  assign fill_index       = base_reg[INDEX_W+1:2];
  assign fill_tag         = base_reg[ADDR_W-1:INDEX_W+2];
  assign unused_addr_lsbs = ^req_addr_i[1:0];

  assign hit      = |way_hit;
  assign hit_word = way_hit[0] ? data_mem[0][req_index] : data_mem[1][req_index];

  // Fill invalid ways first, only then evict by LRU.
  assign victim = !valid_reg[0][fill_index] ? 1'b0 :
                  !valid_reg[1][fill_index] ? 1'b1 : lru_reg[fill_index];

  assign fill_done = (state_reg == FILL) && mem_rdy_i && !flush_i && !rst &&
                     (count_reg == 2'd3);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign way_hit[gi] = valid_reg[gi][req_index] && (tag_mem[gi][req_index] == req_tag);

      always_ff @(posedge clk) begin
        if (fill_done && (victim == 1'(gi))) begin
          tag_mem[gi][fill_index]  <= fill_tag;
          data_mem[gi][fill_index] <= {mem_data_i, asm_reg[23:0]};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_i && !flush_i && !hit) state_next = FILL;
      FILL: begin
        if (flush_i)                                state_next = IDLE;
        else if (mem_rdy_i && count_reg == 2'd3)    state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdy_o      = 1'b0;
    inst_o     = '0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    case (state_reg)
      IDLE: begin
        rdy_o  = req_i && hit && !flush_i;
        inst_o = rdy_o ? hit_word : '0;
      end
      FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_reg + ADDR_W'(count_reg);
      end
      RESP: begin
        rdy_o  = req_i;
        inst_o = req_i ? asm_reg : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      lru_reg   <= '0;
      count_reg <= '0;
      base_reg  <= '0;
      asm_reg   <= '0;
    end else begin
      if (flush_i) begin
        valid_reg <= '0;
        lru_reg   <= '0;
      end
      case (state_reg)
        IDLE: begin
          if (req_i && !flush_i) begin
            // LRU names the way to evict next, so a hit in way0 points it at way1.
            if (hit) lru_reg[req_index] <= way_hit[0];
            else begin
              base_reg  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              count_reg <= '0;
            end
          end
        end
        FILL: begin
          if (mem_rdy_i && !flush_i) begin
            asm_reg[{count_reg, 3'b000} +: 8] <= mem_data_i;
            count_reg <= count_reg + 2'd1;
            if (count_reg == 2'd3) begin
              valid_reg[victim][fill_index] <= 1'b1;
              lru_reg[fill_index]           <= ~victim;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/icache_2way.md
# icache_2way

Parametrised two-way set-associative instruction cache with its own refill engine. It sits between the IF stage and the byte-wide memory controller. Lookups are answered combinationally on a hit. On a miss it fetches the 32-bit instruction over the 8-bit memory port, fills an LRU-selected way, and returns the word. A flush input invalidates the whole cache for fence.i.

## Interface
Parameters:
- ADDR_W, 17, instruction address width
- INDEX_W, 6, set-index bits (sets = 2^INDEX_W); address fields are tag = addr[ADDR_W-1:INDEX_W+2], index = addr[INDEX_W+1:2], addr[1:0] ignored

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  invalidate all lines (fence.i)
- req_i  in  1  IF fetch request; held with stable address until rdy_o
- req_addr_i  in  ADDR_W  fetch address
- rdy_o  out  1  inst_o valid this cycle; request complete
- inst_o  out  32  fetched instruction
- mem_req_o  out  1  byte read request to memory controller
- mem_addr_o  out  ADDR_W  byte address of current read
- mem_rdy_i  in  1  memory byte valid this cycle; accepts current mem_addr_o
- mem_data_i  in  8  returned byte

## Operation
- Storage per set: valid[2], tag[2], data[2] (32 b), one LRU bit (the way to evict next).
- States: IDLE, FILL, RESP.
- IDLE, req_i=1, hit in either way: rdy_o=1 and inst_o=data same cycle (combinational). The LRU bit of that set points at the other way at the next edge.
- IDLE, req_i=1, miss: latch the base address (addr with [1:0]=0), the index and the tag, clear the byte counter to 0, and go to FILL.
- FILL:
  - mem_req_o=1 and mem_addr_o=base+count.
  - Each mem_rdy_i cycle stores mem_data_i into byte [count] of the assembly register (little-endian: byte 0 → bits 7:0) and increments count.
  - On the 4th byte, write the line into the victim way, set valid, set LRU to the other way, and go to RESP.
- Victim way: way0 if invalid; else way1 if invalid; else the way given by the LRU bit.
- RESP: rdy_o=1 and inst_o=assembled word for exactly one cycle, then IDLE. If req_i is low in RESP, rdy_o stays 0; the line is still written.
- Flush:
  - flush_i in IDLE or RESP clears all valid and LRU bits at the edge.
  - flush_i has priority over a same-cycle hit: rdy_o=0 in that cycle.
  - flush_i in FILL aborts the fill: no array write, mem_req_o drops next cycle, FSM goes to IDLE, no rdy_o.
- req_i dropping during FILL does not abort; the fill completes and the line is written.
- inst_o=0 whenever rdy_o=0.

## Timing
- Reset (synchronous): state=IDLE, all valid=0, LRU=0, count=0. Outputs: rdy_o=0, inst_o=0, mem_req_o=0, mem_addr_o=0.
- Reset mid-FILL abandons the fill with no array write; mem_req_o=0 the cycle after reset is sampled.
- Hit latency is 0 cycles: rdy_o is in the same cycle as req_i.
- Miss latency: the 1st mem_req_o is the cycle after the miss. With mem_rdy_i high every cycle, the bytes arrive in cycles 1–4 and rdy_o is in cycle 5.
- mem_addr_o changes only on the cycle after an accepted byte and is held stable while mem_rdy_i=0.
- A line written in cycle N (the 4th-byte edge) is visible to a hit lookup from cycle N+1.
- The back-to-back request after RESP is looked up in the following IDLE cycle.

## Test plan
- Cold miss:
  - Stimulus: after reset, req 0x00100; memory returns 0x13,0x05,0x00,0x00 with mem_rdy_i high every cycle.
  - Required: mem_addr_o goes 0x100..0x103, then rdy_o with inst_o=0x00000513 five cycles after req.
- Hit:
  - Stimulus: req 0x00100 again, 0x00102 (same word).
  - Required: rdy_o in the same cycle, inst_o=0x00000513, mem_req_o stays 0.
- LRU conflict (all in set 0):
  - Stimulus: fill 0x100 and 0x200, hit 0x100, then miss 0x300.
  - Required: 0x300 evicts 0x200 (way1); 0x100 still hits; 0x200 then misses.
- Flush:
  - Stimulus: after the fills, pulse flush_i in IDLE, then req 0x100.
  - Required: miss with a 4-byte fill.
  - Stimulus: flush_i on the 2nd byte of a fill.
  - Required: no rdy_o, mem_req_o low next cycle, the address still misses afterwards.
- Stalled memory:
  - Stimulus: insert 3 idle cycles (mem_rdy_i=0) before each byte.
  - Required: mem_addr_o is held stable during the stall, and rdy_o comes 17 cycles after req with the correct word.
- Reset mid-fill:
  - Stimulus: assert rst after byte 2.
  - Required: all outputs 0 next cycle; a subsequent req to the same address misses.
